// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the streaming memory reader: controller state
// encoding and the fixed request type it drives onto the memreq port.
package mem_stream_reader_pkg;

    // Controller states: idle/accepting, issuing reads, waiting for the tail.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // This block only ever reads from memory.
    localparam logic MEMREQ_RW_READ = 1'b0;

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// Response buffer for the stream reader: DEPTH x WIDTH synchronous FIFO with
// simultaneous push/pop and an occupancy count used for request credits.
module mem_stream_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full buffer is fine.
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero when empty so the stream output has a clean idle value.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are qualified by count, so no reset is needed.
    // NOTE: the data array is deliberately left unreset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Reads a contiguous block of words over memreq/memresp and streams them out
// on a val/rdy port. Requests are credit-limited so the ready-less response
// port can never overrun the response buffer.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int ADDR_SZ   = 8,
    parameter int DATA_SZ   = 32,
    parameter int LEN_SZ    = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_SZ-1:0] cmd_bits_addr,
    input  logic [LEN_SZ-1:0]  cmd_bits_len,
    input  logic               cmd_val,
    output logic               cmd_rdy,
    output logic               memreq_bits_rw,
    output logic [ADDR_SZ-1:0] memreq_bits_addr,
    output logic [DATA_SZ-1:0] memreq_bits_data,
    output logic               memreq_val,
    input  logic               memreq_rdy,
    input  logic [DATA_SZ-1:0] memresp_bits_data,
    input  logic               memresp_val,
    output logic [DATA_SZ-1:0] out_bits,
    output logic               out_val,
    input  logic               out_rdy,
    output logic               busy,
    output logic               done
);

    localparam int                 CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam logic [ADDR_SZ-1:0] STRIDE = ADDR_SZ'(DATA_SZ / 8);

    state_e             state;
    state_e             state_next;
    logic [ADDR_SZ-1:0] req_addr;
    logic [LEN_SZ-1:0]  remaining;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   fifo_count;
    logic               zero_done;
    logic               drain_done;
    logic               credit_ok;
    logic               cmd_fire;
    logic               memreq_fire;
    logic               resp_accept;
    logic               out_fire;

    assign cmd_fire    = cmd_val && cmd_rdy;
    assign memreq_fire = memreq_val && memreq_rdy;
    // Responses with nothing outstanding are stale (e.g. from before a reset).
    assign resp_accept = memresp_val && (outstanding != '0);
    assign out_fire    = out_val && out_rdy;

    // Credit > 0 means buffered plus in-flight words leave a free slot.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W + 1)'(BUF_DEPTH);

    assign memreq_bits_rw   = MEMREQ_RW_READ;
    assign memreq_bits_addr = req_addr;
    assign memreq_bits_data = '0;
    assign out_val          = (fifo_count != '0);
    assign done             = zero_done || drain_done;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake outputs, all derived from registered state.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        cmd_rdy    = 1'b0;
        memreq_val = 1'b0;
        busy       = 1'b1;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                cmd_rdy = !reset;
                if (cmd_fire && (cmd_bits_len != '0)) state_next = ISSUE;
            end
            ISSUE: begin
                memreq_val = credit_ok;
                if (memreq_fire && (remaining == LEN_SZ'(1))) state_next = DRAIN;
            end
            DRAIN: begin
                if ((outstanding == '0) && (fifo_count == '0)) begin
                    state_next = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address/length/in-flight counters and the zero-length done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr    <= '0;
            remaining   <= '0;
            outstanding <= '0;
            zero_done   <= 1'b0;
        end else begin
            zero_done <= cmd_fire && (cmd_bits_len == '0);
            if (cmd_fire) begin
                req_addr  <= cmd_bits_addr;
                remaining <= cmd_bits_len;
            end else if (memreq_fire) begin
                req_addr  <= req_addr + STRIDE;
                remaining <= remaining - LEN_SZ'(1);
            end
            outstanding <= outstanding + CNT_W'(memreq_fire) - CNT_W'(resp_accept);
        end
    end

    mem_stream_reader_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_SZ)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (resp_accept),
        .push_data (memresp_bits_data),
        .pop       (out_fire),
        .pop_data  (out_bits),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: an in-order memory model with
// optional random latency/ready, a stream sink, and a reference expectation
// computed directly from the block address arithmetic.
module tb_mem_stream_reader;

    localparam int ADDR_SZ   = 8;
    localparam int DATA_SZ   = 32;
    localparam int LEN_SZ    = 8;
    localparam int BUF_DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [ADDR_SZ-1:0] cmd_bits_addr;
    logic [LEN_SZ-1:0]  cmd_bits_len;
    logic               cmd_val;
    logic               cmd_rdy;
    logic               memreq_bits_rw;
    logic [ADDR_SZ-1:0] memreq_bits_addr;
    logic [DATA_SZ-1:0] memreq_bits_data;
    logic               memreq_val;
    logic               memreq_rdy;
    logic [DATA_SZ-1:0] memresp_bits_data;
    logic               memresp_val;
    logic [DATA_SZ-1:0] out_bits;
    logic               out_val;
    logic               out_rdy;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    mem_stream_reader #(
        .ADDR_SZ   (ADDR_SZ),
        .DATA_SZ   (DATA_SZ),
        .LEN_SZ    (LEN_SZ),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_bits_addr     (cmd_bits_addr),
        .cmd_bits_len      (cmd_bits_len),
        .cmd_val           (cmd_val),
        .cmd_rdy           (cmd_rdy),
        .memreq_bits_rw    (memreq_bits_rw),
        .memreq_bits_addr  (memreq_bits_addr),
        .memreq_bits_data  (memreq_bits_data),
        .memreq_val        (memreq_val),
        .memreq_rdy        (memreq_rdy),
        .memresp_bits_data (memresp_bits_data),
        .memresp_val       (memresp_val),
        .out_bits          (out_bits),
        .out_val           (out_val),
        .out_rdy           (out_rdy),
        .busy              (busy),
        .done              (done)
    );

    typedef struct {
        logic [DATA_SZ-1:0] data;
        int                 due;
    } resp_t;

    // Memory image (word-addressed by byte address [7:2]) and environment state.
    logic [DATA_SZ-1:0] mem_words [64];
    resp_t              pend[$];
    logic [ADDR_SZ-1:0] req_log[$];
    logic [DATA_SZ-1:0] rx[$];
    int                 rx_cyc[$];
    int                 lat_max  = 0;
    bit                 rdy_rand = 1'b0;
    int                 done_count = 0;
    int                 done_cyc = 0;
    bit                 val_seen = 1'b0;
    int                 cyc = 0;
    int                 fire_cyc = 0;
    int                 errors = 0;
    int                 checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and monitors; everything is evaluated on the falling edge.
    initial begin
        int    cur;
        resp_t r;
        memresp_val       = 1'b0;
        memresp_bits_data = '0;
        memreq_rdy        = 1'b1;
        forever begin
            @(negedge clk);
            cur = cyc + 1;
            memresp_val = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cur) begin
                r = pend.pop_front();
                memresp_val       = 1'b1;
                memresp_bits_data = r.data;
            end
            memreq_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!reset) begin
                if (memreq_val) val_seen = 1'b1;
                if (memreq_val && memreq_rdy) begin
                    req_log.push_back(memreq_bits_addr);
                    r.data = mem_words[memreq_bits_addr[7:2]];
                    r.due  = cur + 1 + int'($urandom_range(0, lat_max));
                    pend.push_back(r);
                end
                if (out_val && out_rdy) begin
                    rx.push_back(out_bits);
                    rx_cyc.push_back(cur);
                end
                if (done) begin
                    done_count++;
                    done_cyc = cur;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "bench did not terminate");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cmd_rdy"},     64'(cmd_rdy),          64'd0);
        check({tag, ".memreq_val"},  64'(memreq_val),       64'd0);
        check({tag, ".memreq_addr"}, 64'(memreq_bits_addr), 64'd0);
        check({tag, ".out_val"},     64'(out_val),          64'd0);
        check({tag, ".out_bits"},    64'(out_bits),         64'd0);
        check({tag, ".busy"},        64'(busy),             64'd0);
        check({tag, ".done"},        64'(done),             64'd0);
    endtask

    task automatic start_cmd(input logic [7:0] addr, input logic [7:0] len, input string tag);
        int n;
        req_log.delete();
        rx.delete();
        rx_cyc.delete();
        done_count = 0;
        val_seen   = 1'b0;
        cmd_bits_addr = addr;
        cmd_bits_len  = len;
        cmd_val       = 1'b1;
        n = 0;
        while (!cmd_rdy && n < 50) begin
            tick(1);
            n++;
        end
        check({tag, ".cmd_rdy"}, 64'(cmd_rdy), 64'd1);
        tick(1);
        fire_cyc = cyc;
        cmd_val  = 1'b0;
    endtask

    // Wait for completion and compare against the block-read reference.
    task automatic finish_xfer(input logic [7:0] addr, input logic [7:0] len,
                               input bit rand_out, input bit timing, input string tag);
        int         n;
        logic [7:0] a;
        n = 0;
        while (done_count == 0 && n < 2000) begin
            if (rand_out) out_rdy = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        out_rdy = 1'b1;
        tick(4);
        check({tag, ".done_count"}, 64'(done_count),     64'd1);
        check({tag, ".words"},      64'(rx.size()),      64'(len));
        check({tag, ".requests"},   64'(req_log.size()), 64'(len));
        for (int i = 0; i < int'(len); i++) begin
            a = addr + 8'(4 * i);
            if (i < rx.size())      check({tag, ".data"}, 64'(rx[i]),      64'(mem_words[a[7:2]]));
            if (i < req_log.size()) check({tag, ".addr"}, 64'(req_log[i]), 64'(a));
        end
        if (timing) begin
            check({tag, ".done_latency"}, 64'(done_cyc - fire_cyc),
                  (len == 0) ? 64'd1 : 64'(int'(len) + 3));
            if (len > 1 && rx.size() == int'(len))
                check({tag, ".throughput"}, 64'(rx_cyc[len-1] - rx_cyc[0]), 64'(int'(len) - 1));
        end
        check({tag, ".busy_after"},    64'(busy),    64'd0);
        check({tag, ".cmd_rdy_after"}, 64'(cmd_rdy), 64'd1);
        check({tag, ".out_val_after"}, 64'(out_val), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_words[i] = $urandom;
        mem_words[0]  = 32'haaaaaaaa;
        mem_words[1]  = 32'hbbbbbbbb;
        mem_words[2]  = 32'hcccccccc;
        reset         = 1'b1;
        cmd_val       = 1'b0;
        cmd_bits_addr = '0;
        cmd_bits_len  = '0;
        out_rdy       = 1'b1;

        // Reset values.
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        check("reset.cmd_rdy_release", 64'(cmd_rdy), 64'd1);

        // Basic three-word read with latency and throughput.
        start_cmd(8'h00, 8'd3, "basic");
        finish_xfer(8'h00, 8'd3, 1'b0, 1'b1, "basic");

        // Longer read at full rate.
        start_cmd(8'h30, 8'd8, "stream8");
        finish_xfer(8'h30, 8'd8, 1'b0, 1'b1, "stream8");

        // Zero length: done one cycle after the command, no request ever.
        start_cmd(8'h40, 8'd0, "zero");
        finish_xfer(8'h40, 8'd0, 1'b0, 1'b1, "zero");
        check("zero.memreq_val_seen", 64'(val_seen), 64'd0);

        // Backpressure: credits cap issue at BUF_DEPTH words.
        out_rdy = 1'b0;
        start_cmd(8'h20, 8'd8, "bp");
        tick(20);
        check("bp.requests_held", 64'(req_log.size()), 64'(BUF_DEPTH));
        check("bp.memreq_val",    64'(memreq_val),     64'd0);
        check("bp.out_val",       64'(out_val),        64'd1);
        check("bp.busy",          64'(busy),           64'd1);
        check("bp.rw",            64'(memreq_bits_rw), 64'd0);
        check("bp.wdata",         64'(memreq_bits_data), 64'd0);
        out_rdy = 1'b1;
        finish_xfer(8'h20, 8'd8, 1'b0, 1'b0, "bp");

        // Address wrap at the top of the byte address space.
        mem_words[63] = 32'h11111111;
        mem_words[0]  = 32'h22222222;
        start_cmd(8'hfc, 8'd2, "wrap");
        finish_xfer(8'hfc, 8'd2, 1'b0, 1'b0, "wrap");

        // Random memory latency, random memreq_rdy and random out_rdy.
        lat_max  = 5;
        rdy_rand = 1'b1;
        start_cmd(8'h40, 8'd6, "rand");
        finish_xfer(8'h40, 8'd6, 1'b1, 1'b0, "rand");
        start_cmd(8'h90, 8'd11, "rand2");
        finish_xfer(8'h90, 8'd11, 1'b1, 1'b0, "rand2");
        lat_max  = 0;
        rdy_rand = 1'b0;

        // Reset two cycles into a transfer, then a clean follow-up read.
        start_cmd(8'h80, 8'd6, "midrst");
        tick(1);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        reset = 1'b0;
        tick(10);
        check("midrst.idle_out_val", 64'(out_val), 64'd0);
        check("midrst.idle_busy",    64'(busy),    64'd0);
        start_cmd(8'h10, 8'd2, "after_rst");
        finish_xfer(8'h10, 8'd2, 1'b0, 1'b1, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Memory-side initiator that reads a contiguous block of words through the team's memreq/memresp port and presents the data as a val/rdy stream. It is the requester counterpart of the magic and test memories and sits between a memory port and any stream consumer, such as the FFT input loader. Requests are credit-limited so the response port, which has no ready, can never overflow the internal buffer.

## Interface
- ADDR_SZ, 8, byte-address width.
- DATA_SZ, 32, word width. The word stride is DATA_SZ/8 bytes.
- LEN_SZ, 8, width of the word-count field.
- BUF_DEPTH, 4, response buffer depth and maximum words in flight (power of two, ≥2).

- clk  in  1  clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- cmd_bits_addr  in  ADDR_SZ  start byte address.
- cmd_bits_len  in  LEN_SZ  number of words to read.
- cmd_val / cmd_rdy  in / out  1  command handshake.
- memreq_bits_rw  out  1  constant 0 (read).
- memreq_bits_addr  out  ADDR_SZ  request address.
- memreq_bits_data  out  DATA_SZ  constant 0.
- memreq_val / memreq_rdy  out / in  1  request handshake.
- memresp_bits_data  in  DATA_SZ  response data.
- memresp_val  in  1  response valid. There is no ready on this port.
- out_bits  out  DATA_SZ  streamed word.
- out_val / out_rdy  out / in  1  stream handshake.
- busy  out  1  high whenever the block is not IDLE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- A transfer fires when val & rdy are both high in the same cycle.
- **State machine**: IDLE, ISSUE, DRAIN.
- **IDLE**
  - cmd_rdy=1.
  - On a cmd fire, latch addr into req_addr and len into remaining.
  - If len≠0, go to ISSUE.
  - If len=0, stay in IDLE and assert done on the next cycle. No memreq is issued.
- **ISSUE**
  - memreq_val = (credit > 0).
  - credit = BUF_DEPTH − fifo_count − outstanding, computed from registered values only.
  - On a memreq fire: req_addr += DATA_SZ/8, wrapping mod 2^ADDR_SZ; remaining −= 1; outstanding += 1.
  - The fire that takes remaining from 1 to 0 moves the FSM to DRAIN.
- **DRAIN**
  - memreq_val=0.
  - When outstanding=0 and the FIFO is empty, return to IDLE and pulse done in that same transition cycle.
- **Responses**
  - Each memresp_val pushes memresp_bits_data into the FIFO and decrements outstanding.
  - A memreq fire and a response in the same cycle leave outstanding unchanged.
  - A response is never dropped while outstanding > 0.
  - The credit rule guarantees the FIFO never overflows.
  - memresp_val while outstanding=0 is ignored: no push, no counter change.
- **Output**: out_val = FIFO non-empty; out_bits = FIFO head. A push and a pop in the same cycle are both honoured, even when the FIFO is full or empty.
- **Ordering**: words leave in request order. The memory returns responses in order.
- **Reset** (at any time, including mid-transfer):
  - FSM → IDLE; FIFO, outstanding, remaining and req_addr are cleared.
  - Responses still in flight are discarded by the outstanding=0 rule.

## Timing
- **Reset values**: cmd_rdy=0 while reset is high and 1 after it; memreq_val=0; memreq_bits_addr=0; out_val=0; out_bits=0; busy=0; done=0.
- **Command to first request**: the cmd fire at cycle t gives memreq_val=1 at t+1.
- **Combinational paths**:
  - memreq_val and memreq_bits_addr come from registers only, with no path from memreq_rdy.
  - cmd_rdy likewise has no path from cmd_val.
- **Response to output**: memresp_val at cycle t gives out_val at t+1.
- **Throughput**: with a 1-cycle memory and out_rdy held high, one word per cycle after the first.
- **Command to done, magic memory, out_rdy=1**: a command of N words asserts done at cmd-fire cycle + N + 3.
- **Backpressure**: with out_rdy held low, at most BUF_DEPTH requests are issued before memreq_val drops.

## Structure
- **Shared package** (vcMemories-level): state encodings IDLE/ISSUE/DRAIN and the constant memreq_rw read value (0).
- **Counter widths**: outstanding and fifo_count are clog2(BUF_DEPTH)+1 bits.
- **Sub-module**: mem_stream_reader_fifo, a BUF_DEPTH × DATA_SZ synchronous FIFO with simultaneous push/pop and a count output.
- **Top module**: FSM, address/remaining counters, outstanding counter and credit logic.

## Test plan
- **Basic read**: magic1port preloaded 0x00=aaaaaaaa, 0x04=bbbbbbbb, 0x08=cccccccc; cmd addr=0x00 len=3 → sink receives aaaaaaaa, bbbbbbbb, cccccccc; one done pulse; busy low afterwards.
- **Zero length**: cmd len=0 → no memreq_val ever; done pulses one cycle after the cmd fire; cmd_rdy stays 1.
- **Backpressure**: cmd len=8, out_rdy=0 for 20 cycles → exactly 4 memreq fires, FIFO full, memreq_val=0. Release out_rdy → all 8 words arrive in address order.
- **Wrap**: memory 0xfc=11111111, 0x00=22222222; cmd addr=0xfc len=2 → requests at 0xfc then 0x00; output 11111111, 22222222.
- **Random latency**: test1port with RAND_DELAY=5, len=6 → sink sees all 6 preloaded words in order.
- **Mid-transfer reset**: assert reset 2 cycles into a len=6 transfer → outputs return to reset values. A following len=2 command yields exactly 2 correct words and no stale data.
